// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto a single 1-cycle-latency memory port.
// Build option ARB_ROUND_ROBIN_EN: alternate winners on contention; otherwise data has fixed priority.
//
// state   | meaning
// IDLE    | no response outstanding (pending=0)
// RESP    | a response returns this cycle to owner_q (pending=1)
module mem_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [7:0]  i_we,
  input  logic [63:0] i_addr,
  input  logic [63:0] i_wdata,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [63:0] i_rdata,
  input  logic        d_req,
  input  logic [7:0]  d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic        mem_en,
  output logic [7:0]  mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_gnt_q, last_gnt_d;
  logic   gnt_i, gnt_d, any_gnt, resp_ok;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (!reset) begin
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (last_gnt_q == OWN_INST) gnt_d = 1'b1;
        else                        gnt_i = 1'b1;
`else
        gnt_d = 1'b1;
`endif
      end else if (i_req) begin
        gnt_i = 1'b1;
      end else if (d_req) begin
        gnt_d = 1'b1;
      end
    end
    any_gnt = gnt_i | gnt_d;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_i) begin
      mem_en    = 1'b1;
      mem_we    = i_we;
      mem_addr  = i_addr;
      mem_wdata = i_wdata;
    end else if (gnt_d) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      ST_IDLE: if (any_gnt) state_d = ST_RESP;
      ST_RESP: if (!any_gnt) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (any_gnt) begin
      owner_d    = gnt_d ? OWN_DATA : OWN_INST;
      last_gnt_d = gnt_d ? OWN_DATA : OWN_INST;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_INST;
      last_gnt_q <= OWN_INST;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // A response still in flight when reset rises is dropped, not delivered.
  always_comb begin
    resp_ok  = (state_q == ST_RESP) && !reset;
    i_gnt    = gnt_i;
    d_gnt    = gnt_d;
    i_rvalid = resp_ok && (owner_q == OWN_INST);
    d_rvalid = resp_ok && (owner_q == OWN_DATA);
    i_rdata  = i_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
    busy     = (state_q == ST_RESP);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic vs. a request-level model.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req, d_req;
  logic [7:0]  i_we, d_we;
  logic [63:0] i_addr, i_wdata, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [63:0] i_rdata, d_rdata;
  logic        mem_en;
  logic [7:0]  mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Model: who wins this cycle, who gets a response this cycle, and who won most recently.
  int exp_resp = -1;
  int mdl_last = 0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  // -1 none, 0 instruction, 1 data
  function automatic int exp_winner(input logic ir, input logic dr, input logic rst, input int lastw);
    if (rst) return -1;
    if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (lastw == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    if (ir) return 0;
    if (dr) return 1;
    return -1;
  endfunction

  always @(posedge clock) begin
    int w;
    w = exp_winner(i_req, d_req, reset, mdl_last);
    exp_resp = w;
    if (reset) mdl_last = 0;
    else if (w >= 0) mdl_last = w;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    i_req = 0; d_req = 0;
    i_we = '0; d_we = '0;
    i_addr = '0; d_addr = '0;
    i_wdata = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1; i_req = 1; d_req = 1; mem_rdata = 64'hDEAD_BEEF_0000_0001;
    for (int c = 0; c < 2; c++) begin
      #4;
      total++;
      if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0) begin
        bad++;
        $display("FAIL reset_gnt cyc%0d: i_gnt=%b d_gnt=%b mem_en=%b required 0 0 0", c, i_gnt, d_gnt, mem_en);
      end
      tick();
    end
    reset = 0; drive_idle();
    #4;
    total++;
    if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || busy !== 1'b0 || i_rdata !== 64'd0 || d_rdata !== 64'd0) begin
      bad++;
      $display("FAIL reset_state: i_rv=%b d_rv=%b busy=%b i_rd=%h d_rd=%h required all 0",
               i_rvalid, d_rvalid, busy, i_rdata, d_rdata);
    end
    tick();
  endtask

  task automatic test_idle();
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      #4;
      total++;
      if (mem_en !== 1'b0 || i_gnt !== 1'b0 || d_gnt !== 1'b0 || i_rvalid !== 1'b0 ||
          d_rvalid !== 1'b0 || busy !== 1'b0 || mem_addr !== 64'd0 || mem_we !== 8'd0) begin
        bad++;
        $display("FAIL idle cyc%0d: mem_en=%b gnt=%b%b rv=%b%b busy=%b addr=%h we=%h required all 0",
                 c, mem_en, i_gnt, d_gnt, i_rvalid, d_rvalid, busy, mem_addr, mem_we);
      end
      tick();
    end
  endtask

  task automatic test_inst_read();
    drive_idle();
    i_req = 1; i_addr = 64'h8000_0000;
    #4;
    total++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 64'h8000_0000 || mem_we !== 8'h00) begin
      bad++;
      $display("FAIL inst_read_gnt: i_gnt=%b d_gnt=%b mem_en=%b addr=%h we=%h required 1 0 1 80000000 00",
               i_gnt, d_gnt, mem_en, mem_addr, mem_we);
    end
    tick();
    drive_idle();
    mem_rdata = 64'h0000_0013_0000_0093;
    #4;
    total++;
    if (i_rvalid !== 1'b1 || i_rdata !== 64'h0000_0013_0000_0093 || d_rvalid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL inst_read_resp: i_rv=%b i_rd=%h d_rv=%b busy=%b required 1 0000001300000093 0 1",
               i_rvalid, i_rdata, d_rvalid, busy);
    end
    tick();
  endtask

  task automatic test_data_write();
    drive_idle();
    d_req = 1; d_we = 8'hFF; d_addr = 64'h8000_1000; d_wdata = 64'h1122_3344_5566_7788;
    #4;
    total++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 8'hFF ||
        mem_addr !== 64'h8000_1000 || mem_wdata !== 64'h1122_3344_5566_7788) begin
      bad++;
      $display("FAIL data_write_gnt: d_gnt=%b i_gnt=%b mem_en=%b we=%h addr=%h wdata=%h required 1 0 1 ff 80001000 1122334455667788",
               d_gnt, i_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    drive_idle();
    mem_rdata = 64'h5A5A_0000_1111_2222;
    #4;
    total++;
    if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== 64'h5A5A_0000_1111_2222 || i_rdata !== 64'd0) begin
      bad++;
      $display("FAIL data_write_resp: d_rv=%b i_rv=%b d_rd=%h i_rd=%h required 1 0 5a5a000011112222 0",
               d_rvalid, i_rvalid, d_rdata, i_rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    logic exp_d [4];
`ifdef ARB_ROUND_ROBIN_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    reset = 1; drive_idle();
    tick();
    reset = 0;
    i_req = 1; d_req = 1; i_addr = 64'h100; d_addr = 64'h200;
    for (int c = 0; c < 4; c++) begin
      #4;
      total++;
      if (d_gnt !== exp_d[c] || i_gnt !== !exp_d[c] || mem_addr !== (exp_d[c] ? 64'h200 : 64'h100)) begin
        bad++;
        $display("FAIL contention cyc%0d: d_gnt=%b i_gnt=%b addr=%h required d_gnt=%b i_gnt=%b",
                 c, d_gnt, i_gnt, mem_addr, exp_d[c], !exp_d[c]);
      end
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_alternating();
    logic is_d [3];
    is_d = '{1'b0, 1'b1, 1'b0};
    drive_idle();
    for (int c = 0; c < 5; c++) begin
      drive_idle();
      if (c < 3) begin
        if (is_d[c]) d_req = 1; else i_req = 1;
      end
      mem_rdata = 64'h1000 + 64'(c);
      #4;
      if (c >= 1 && c <= 3) begin
        total++;
        if (busy !== 1'b1 || i_rvalid !== !is_d[c-1] || d_rvalid !== is_d[c-1] ||
            (is_d[c-1] ? d_rdata : i_rdata) !== 64'h1000 + 64'(c)) begin
          bad++;
          $display("FAIL alternating cyc%0d: busy=%b i_rv=%b d_rv=%b required busy=1 i_rv=%b d_rv=%b",
                   c, busy, i_rvalid, d_rvalid, !is_d[c-1], is_d[c-1]);
        end
      end else if (c == 4) begin
        total++;
        if (busy !== 1'b0 || i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
          bad++;
          $display("FAIL alternating_end: busy=%b i_rv=%b d_rv=%b required 0 0 0", busy, i_rvalid, d_rvalid);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_drop();
    drive_idle();
    i_req = 1; i_addr = 64'h40;
    tick();
    drive_idle();
    reset = 1;
    #4;
    total++;
    if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || i_rdata !== 64'd0) begin
      bad++;
      $display("FAIL reset_drop_during: i_rv=%b d_rv=%b i_rd=%h required 0 0 0", i_rvalid, d_rvalid, i_rdata);
    end
    tick();
    reset = 0;
    for (int c = 0; c < 2; c++) begin
      #4;
      total++;
      if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_drop_after cyc%0d: i_rv=%b d_rv=%b busy=%b required 0 0 0", c, i_rvalid, d_rvalid, busy);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int w, rsp;
    logic [63:0] ea, ew;
    logic [7:0]  ewe;
    for (int c = 0; c < 400; c++) begin
      reset   = ($urandom_range(0, 24) == 0);
      i_req   = ($urandom_range(0, 2) != 0);
      d_req   = ($urandom_range(0, 2) != 0);
      i_we    = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      d_we    = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      i_addr  = {$urandom, $urandom};
      d_addr  = {$urandom, $urandom};
      i_wdata = {$urandom, $urandom};
      d_wdata = {$urandom, $urandom};
      mem_rdata = {$urandom, $urandom};
      w = exp_winner(i_req, d_req, reset, mdl_last);
      rsp = reset ? -1 : exp_resp;
      ea  = (w == 0) ? i_addr  : (w == 1) ? d_addr  : 64'd0;
      ew  = (w == 0) ? i_wdata : (w == 1) ? d_wdata : 64'd0;
      ewe = (w == 0) ? i_we    : (w == 1) ? d_we    : 8'd0;
      #4;
      total++;
      if (i_gnt !== (w == 0) || d_gnt !== (w == 1) || mem_en !== (w >= 0) ||
          mem_addr !== ea || mem_wdata !== ew || mem_we !== ewe) begin
        bad++;
        $display("FAIL rand_req cyc%0d: gnt=%b%b en=%b we=%h addr=%h wd=%h required gnt=%b%b en=%b we=%h addr=%h wd=%h",
                 c, i_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                 (w == 0), (w == 1), (w >= 0), ewe, ea, ew);
      end
      total++;
      if (i_rvalid !== (rsp == 0) || d_rvalid !== (rsp == 1) ||
          i_rdata !== ((rsp == 0) ? mem_rdata : 64'd0) || d_rdata !== ((rsp == 1) ? mem_rdata : 64'd0) ||
          busy !== (exp_resp >= 0)) begin
        bad++;
        $display("FAIL rand_resp cyc%0d: rv=%b%b busy=%b i_rd=%h d_rd=%h required rv=%b%b busy=%b",
                 c, i_rvalid, d_rvalid, busy, i_rdata, d_rdata, (rsp == 0), (rsp == 1), (exp_resp >= 0));
      end
      tick();
    end
    reset = 0; drive_idle();
    tick();
  endtask

  initial begin
    reset = 1; drive_idle(); mem_rdata = '0;
    #1;
    tick();
    tick();
    test_reset();
    test_idle();
    test_inst_read();
    test_data_write();
    test_contention();
    test_alternating();
    test_reset_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
